// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: lane width, arbiter FSM encoding and a
// modulo-wrap helper used for round-robin pointers.
package keccak_pkg;

  localparam int w = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FEED  = 2'd1,
    ARB_DRAIN = 2'd2
  } keccak_arb_state_t;

  // Reduce a value known to be below 2*n into the range [0, n).
  function automatic int unsigned rr_wrap(input int unsigned a, input int unsigned n);
    return (a >= n) ? (a - n) : a;
  endfunction

endpackage

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or after the pointer, wrapping modulo N.
module keccak_rr_pick
  import keccak_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] pos_s;
  logic             hit_s;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    pos_s = {IDX_W{1'b0}};
    hit_s = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      pos_s = IDX_W'(rr_wrap(32'(ptr) + i, N));
      hit_s = req[pos_s] && !any;
      idx   = hit_s ? pos_s : idx;
      any   = any | req[pos_s];
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core between N_REQ requesters: whole jobs are granted
// round-robin, input words pass through to the core, outputs go to the owner.
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int W     = w,
  parameter int LEN_W = 16,
  localparam int G_W  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0][W-1:0]     req_data_i,
  input  logic [N_REQ-1:0]            req_last_i,
  input  logic [N_REQ-1:0][LEN_W-1:0] req_olen_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [W-1:0]                rsp_data_o,
  output logic                        rsp_last_o,
  input  logic [N_REQ-1:0]            rsp_ready_i,
  output logic                        core_valid_o,
  output logic [W-1:0]                core_data_o,
  input  logic                        core_ready_i,
  input  logic                        core_valid_i,
  input  logic [W-1:0]                core_data_i,
  output logic                        core_ready_o,
  output logic [G_W-1:0]              grant_o,
  output logic                        busy_o
);

  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  keccak_arb_state_t state_r, state_n;
  logic [G_W-1:0]    grant_r;
  logic [G_W-1:0]    rr_ptr_r;
  logic [LEN_W-1:0]  olen_cnt_r;
  logic              first_r;
  logic [G_W-1:0]    pick_idx_s;
  logic              pick_any_s;
  logic              feed_hs_s;
  logic              drain_hs_s;
  logic              drain_end_s;

  keccak_rr_pick #(
    .N     (N_REQ),
    .IDX_W (G_W)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_r),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  assign feed_hs_s   = (state_r == ARB_FEED) && req_valid_i[grant_r] && core_ready_i;
  assign drain_hs_s  = (state_r == ARB_DRAIN) && core_valid_i && rsp_ready_i[grant_r];
  assign drain_end_s = drain_hs_s && (olen_cnt_r == LEN_ONE);
  assign grant_o     = grant_r;
  assign busy_o      = (state_r != ARB_IDLE);

  // Next-state logic for the job FSM.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_any_s) state_n = ARB_FEED;
        else            state_n = ARB_IDLE;
      end
      ARB_FEED: begin
        if (feed_hs_s && req_last_i[grant_r]) state_n = ARB_DRAIN;
        else                                  state_n = ARB_FEED;
      end
      ARB_DRAIN: begin
        if (drain_end_s) state_n = ARB_IDLE;
        else             state_n = ARB_DRAIN;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Zero-latency handshake routing between the owner and the core.
  always_comb begin
    req_ready_o  = {N_REQ{1'b0}};
    rsp_valid_o  = {N_REQ{1'b0}};
    rsp_data_o   = {W{1'b0}};
    rsp_last_o   = 1'b0;
    core_valid_o = 1'b0;
    core_data_o  = {W{1'b0}};
    core_ready_o = 1'b0;
    case (state_r)
      ARB_FEED: begin
        core_valid_o         = req_valid_i[grant_r];
        core_data_o          = req_data_i[grant_r];
        req_ready_o[grant_r] = core_ready_i;
      end
      ARB_DRAIN: begin
        rsp_valid_o[grant_r] = core_valid_i;
        rsp_data_o           = core_data_i;
        core_ready_o         = rsp_ready_i[grant_r];
        rsp_last_o           = core_valid_i && (olen_cnt_r == LEN_ONE);
      end
      default: begin
        core_ready_o = 1'b0;
      end
    endcase
  end

  // State, owner, output-length counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ARB_IDLE;
      grant_r    <= {G_W{1'b0}};
      rr_ptr_r   <= {G_W{1'b0}};
      olen_cnt_r <= LEN_ZERO;
      first_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      if ((state_r == ARB_IDLE) && pick_any_s) begin
        grant_r <= pick_idx_s;
        first_r <= 1'b1;
      end
      // A declared length of zero still yields one output word.
      if (feed_hs_s && first_r) begin
        olen_cnt_r <= (req_olen_i[grant_r] == LEN_ZERO) ? LEN_ONE : req_olen_i[grant_r];
        first_r    <= 1'b0;
      end
      if (drain_hs_s) begin
        olen_cnt_r <= olen_cnt_r - LEN_ONE;
      end
      if (drain_end_s) begin
        rr_ptr_r <= G_W'(rr_wrap(32'(grant_r) + 32'd1, N_REQ));
      end
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed scoreboard bench for keccak_arbiter: the bench plays the requesters
// and the core, queueing expected core-side and response-side words.
module tb_keccak_arbiter;
  import keccak_pkg::*;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int LW = 16;

  typedef struct {
    int          who;
    logic [DW-1:0] data;
    logic        last;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0][DW-1:0]   req_data;
  logic [N-1:0]           req_last;
  logic [N-1:0][LW-1:0]   req_olen;
  logic [N-1:0]           req_ready_o;
  logic [N-1:0]           rsp_valid_o;
  logic [DW-1:0]          rsp_data_o;
  logic                   rsp_last_o;
  logic [N-1:0]           rsp_ready;
  logic                   core_valid_o;
  logic [DW-1:0]          core_data_o;
  logic                   core_ready;
  logic                   core_valid;
  logic [DW-1:0]          core_data;
  logic                   core_ready_o;
  logic [1:0]             grant_o;
  logic                   busy_o;

  int   n_cmp = 0;
  int   n_err = 0;
  int   feed_hs = 0;
  int   rsp_hs = 0;
  logic feed_now = 1'b0;
  logic rsp_now = 1'b0;
  logic mon_busy = 1'b0;
  logic iso_on = 1'b0;
  exp_t feed_q[$];
  exp_t rsp_q[$];

  keccak_arbiter #(.N_REQ(N), .W(DW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_olen_i   (req_olen),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_last_o   (rsp_last_o),
    .rsp_ready_i  (rsp_ready),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_ready_i (core_ready),
    .core_valid_i (core_valid),
    .core_data_i  (core_data),
    .core_ready_o (core_ready_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe one cycle's handshakes (called mid-cycle) against the scoreboard.
  task automatic mon();
    exp_t       e;
    logic [N-1:0] oh;
    feed_now = 1'b0;
    rsp_now  = 1'b0;
    mon_busy = busy_o;
    if (rst) begin
      if (core_valid_o && core_ready) begin
        feed_now = 1'b1;
        feed_hs++;
        if (feed_q.size() > 0) e = feed_q.pop_front();
        else begin e.who = 7; e.data = {DW{1'bx}}; e.last = 1'bx; end
        oh = 3'b001 << e.who;
        chk("feed_data", core_data_o, e.data);
        chk("feed_owner", 64'(req_ready_o), 64'(oh));
        chk("feed_grant", 64'(grant_o), 64'(e.who));
      end
      if ((rsp_valid_o & rsp_ready) != 3'b000) begin
        rsp_now = 1'b1;
        rsp_hs++;
        if (rsp_q.size() > 0) e = rsp_q.pop_front();
        else begin e.who = 7; e.data = {DW{1'bx}}; e.last = 1'bx; end
        oh = 3'b001 << e.who;
        chk("rsp_owner", 64'(rsp_valid_o), 64'(oh));
        chk("rsp_data", rsp_data_o, e.data);
        chk("rsp_last", 64'(rsp_last_o), 64'(e.last));
        chk("rsp_core_ready", 64'(core_ready_o), 64'd1);
      end
      if (iso_on) begin
        chk("iso_ready2", 64'(req_ready_o[2]), 64'd0);
        chk("iso_rsp2", 64'(rsp_valid_o[2]), 64'd0);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data_o, 64'd0);
    chk({tag, "_rsp_last"}, 64'(rsp_last_o), 64'd0);
    chk({tag, "_core_valid"}, 64'(core_valid_o), 64'd0);
    chk({tag, "_core_data"}, core_data_o, 64'd0);
    chk({tag, "_core_ready"}, 64'(core_ready_o), 64'd0);
    chk({tag, "_grant"}, 64'(grant_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Present one input word from requester r; core_ready held low for stall cycles first.
  task automatic send_word(input int r, input logic [63:0] d, input logic last,
                           input logic [15:0] olen, input int stall);
    int   base;
    logic done;
    req_valid[r] = 1'b1;
    req_data[r]  = d;
    req_last[r]  = last;
    req_olen[r]  = olen;
    feed_q.push_back('{r, d, 1'b0});
    if (stall > 0) begin
      core_ready = 1'b0;
      base = feed_hs;
      repeat (stall) cyc();
      chk("stall_no_feed", 64'(feed_hs), 64'(base));
      core_ready = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc();
      done = feed_now;
    end
    chk("feed_timeout", 64'(done), 64'd1);
    req_valid[r] = 1'b0;
  endtask

  // Offer one core output word to requester r; its rsp_ready held low for stall cycles first.
  task automatic drain_word(input int r, input logic [63:0] d, input logic last, input int stall);
    int   base;
    logic done;
    core_valid = 1'b1;
    core_data  = d;
    rsp_q.push_back('{r, d, last});
    if (stall > 0) begin
      rsp_ready[r] = 1'b0;
      base = rsp_hs;
      repeat (stall) cyc();
      chk("stall_no_rsp", 64'(rsp_hs), 64'(base));
      rsp_ready[r] = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc();
      done = rsp_now;
    end
    chk("rsp_timeout", 64'(done), 64'd1);
    core_valid = 1'b0;
  endtask

  initial begin
    int   base;
    logic prev;
    rst        = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    req_olen   = '0;
    rsp_ready  = 3'b111;
    core_ready = 1'b1;
    core_valid = 1'b1;
    core_data  = 64'h5555_AAAA_5555_AAAA;
    req_data[0] = 64'hDEAD_BEEF_0000_0001;

    // Reset state, then idle with nothing requested.
    cyc();
    cyc();
    check_quiet("rst");
    rst = 1'b1;
    cyc();
    check_quiet("idle");
    core_valid = 1'b0;

    // Round-robin: all three continuously valid with one-word jobs.
    for (int r = 0; r < N; r++) begin
      req_valid[r] = 1'b1;
      req_data[r]  = 64'h100 + 64'(r);
      req_last[r]  = 1'b1;
      req_olen[r]  = 16'd1;
    end
    feed_q.push_back('{0, 64'h100, 1'b0});
    feed_q.push_back('{1, 64'h101, 1'b0});
    feed_q.push_back('{2, 64'h102, 1'b0});
    feed_q.push_back('{0, 64'h100, 1'b0});
    for (int j = 0; j < 4; j++) rsp_q.push_back('{(j == 3) ? 0 : j, 64'hC0DE_0000_0000_00F0, 1'b1});
    core_valid = 1'b1;
    core_data  = 64'hC0DE_0000_0000_00F0;
    base = rsp_hs;
    prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (prev) chk("rr_idle_gap", 64'(mon_busy), 64'd0);
      prev = rsp_now;
      if (rsp_hs == base + 4) break;
    end
    req_valid  = '0;
    core_valid = 1'b0;
    chk("rr_jobs", 64'(rsp_hs - base), 64'd4);
    cyc();
    chk("rr_idle_after", 64'(mon_busy), 64'd0);

    // Single two-word job from requester 0.
    base = rsp_hs;
    send_word(0, 64'h8000010000000020, 1'b0, 16'd1, 0);
    send_word(0, 64'h0615502300000000, 1'b1, 16'd1, 0);
    drain_word(0, 64'h0123_4567_89AB_CDEF, 1'b1, 0);
    chk("single_count", 64'(rsp_hs - base), 64'd1);
    chk("single_idle", 64'(busy_o), 64'd0);

    // Backpressure on requester 1 while requester 2 waits (isolation).
    req_valid[2] = 1'b1;
    req_data[2]  = 64'h2222_2222_2222_2222;
    req_last[2]  = 1'b1;
    req_olen[2]  = 16'd0;
    iso_on = 1'b1;
    base = rsp_hs;
    send_word(1, 64'hAAAA_0000_0000_0001, 1'b0, 16'd4, 0);
    send_word(1, 64'hBBBB_0000_0000_0002, 1'b1, 16'd4, 3);
    drain_word(1, 64'hD000_0000_0000_0000, 1'b0, 0);
    drain_word(1, 64'hD000_0000_0000_0001, 1'b0, 2);
    drain_word(1, 64'hD000_0000_0000_0002, 1'b0, 0);
    drain_word(1, 64'hD000_0000_0000_0003, 1'b1, 0);
    iso_on = 1'b0;
    chk("bp_count", 64'(rsp_hs - base), 64'd4);

    // Requester 2's pending job declares zero outputs; one word is delivered.
    base = rsp_hs;
    send_word(2, 64'h2222_2222_2222_2222, 1'b1, 16'd0, 0);
    drain_word(2, 64'hE000_0000_0000_0002, 1'b1, 0);
    chk("olen0_count", 64'(rsp_hs - base), 64'd1);
    chk("olen0_idle", 64'(busy_o), 64'd0);

    // Move the pointer to 1, then abort requester 1's job in DRAIN.
    send_word(0, 64'h0F0F_0000_0000_0000, 1'b1, 16'd1, 0);
    drain_word(0, 64'hF000_0000_0000_0000, 1'b1, 0);
    send_word(1, 64'h1111_0000_0000_0000, 1'b1, 16'd2, 0);
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    rsp_ready[1] = 1'b0;
    core_valid   = 1'b1;
    core_data    = 64'h7777_7777_7777_7777;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    check_quiet("post_rst");
    rsp_ready[1] = 1'b1;
    core_valid   = 1'b0;

    // After reset, requesters 0 and 1 both valid: requester 0 must win.
    req_valid[1] = 1'b1;
    req_data[1]  = 64'h1111_0000_0000_0009;
    req_last[1]  = 1'b1;
    req_olen[1]  = 16'd1;
    send_word(0, 64'h0000_0000_0000_0A0A, 1'b1, 16'd1, 0);
    drain_word(0, 64'hF000_0000_0000_0A0A, 1'b1, 0);
    req_valid[1] = 1'b0;
    cyc();
    chk("final_idle", 64'(busy_o), 64'd0);
    chk("feed_q_empty", 64'(feed_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
